seq_mul: RTL and testbench

Multi-cycle radix-2 shift-add multiplier with a valid/ready handshake on both sides. It is the sequential successor to the combinational array multiplier: width is parametrised, it adds signed, unsigned and mixed-sign modes, and it holds its result under back-pressure. It sits beside the ALU in the execute stage, takes rs1_reg/rs2_reg operands, and returns the full 2N-bit product on mul_rd.

---
 rtl/seq_mul.sv | 135 +++++++++++++
 tb/tb_seq_mul.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/seq_mul.sv
// Radix-2 shift-add multiplier with valid/ready on both sides; N-cycle latency.
// Optional `SEQ_MUL_EARLY_OUT_EN: finish as soon as the remaining multiplier bits are zero.
module seq_mul #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   rs1_reg,
  input  logic [N-1:0]   rs2_reg,
  input  logic [1:0]     mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] mul_rd
);

  localparam int CW = $clog2(N) + 1;
  localparam int P  = 2 * N;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [P-1:0]    mcand_q, mcand_d;
  logic [N-1:0]    mplier_q, mplier_d;
  logic [P-1:0]    acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic [P-1:0]    mul_rd_q, mul_rd_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic            rs1_neg_s, rs2_neg_s;
  logic [N-1:0]    rs1_mag_s, rs2_mag_s;
  logic [P-1:0]    pp_s, sum_s;
  logic            last_s;

  // Mode 11 decodes like 00: neither operand is treated as signed.
  assign rs1_neg_s = ((mode == 2'b01) || (mode == 2'b10)) && rs1_reg[N-1];
  assign rs2_neg_s = (mode == 2'b01) && rs2_reg[N-1];
  assign rs1_mag_s = rs1_neg_s ? -rs1_reg : rs1_reg;
  assign rs2_mag_s = rs2_neg_s ? -rs2_reg : rs2_reg;

  assign pp_s  = mplier_q[0] ? mcand_q : '0;
  assign sum_s = acc_q + pp_s;

`ifdef SEQ_MUL_EARLY_OUT_EN
  assign last_s = (cnt_q == CW'(N - 1)) || (mplier_q[N-1:1] == '0);
`else
  assign last_s = (cnt_q == CW'(N - 1));
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      mul_rd_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      mul_rd_q    <= mul_rd_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and datapath update; handshake flags follow the next state.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    mul_rd_d = mul_rd_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = {{N{1'b0}}, rs1_mag_s};
          mplier_d = rs2_mag_s;
          neg_d    = rs1_neg_s ^ rs2_neg_s;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = BUSY;
        end else begin
          state_d  = IDLE;
        end
      end
      BUSY: begin
        acc_d    = sum_s;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (last_s) begin
          mul_rd_d = neg_q ? -sum_s : sum_s;
          state_d  = DONE;
        end else begin
          state_d  = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign mul_rd    = mul_rd_q;

endmodule

// File: tb/tb_seq_mul.sv
// Self-checking bench for seq_mul (N=8): directed cases plus randomized operands
// against an arithmetic reference model.
module tb_seq_mul;
  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   rs1_reg;
  logic [N-1:0]   rs2_reg;
  logic [1:0]     mode;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] mul_rd;

  int n_tests = 0;
  int n_fail  = 0;

  seq_mul #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs1_reg   (rs1_reg),
    .rs2_reg   (rs2_reg),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mul_rd    (mul_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint opnd(input logic [7:0] v, input bit sgn);
    if (sgn) return longint'($signed(v));
    else     return longint'(v);
  endfunction

  function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] m);
    longint p;
    p = opnd(a, (m == 2'd1) || (m == 2'd2)) * opnd(b, m == 2'd1);
    return p[15:0];
  endfunction

  function automatic int ref_lat(input logic [7:0] b, input logic [1:0] m);
`ifdef SEQ_MUL_EARLY_OUT_EN
    longint y;
    int hb;
    y  = opnd(b, m == 2'd1);
    if (y < 0) y = -y;
    hb = -1;
    for (int i = 0; i < N; i++) if (y[i]) hb = i;
    return (hb < 0) ? 1 : hb + 1;
`else
    return N;
`endif
  endfunction

  // One full transaction: accept, wait for completion, optional stall with ignored pokes, handoff.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                        input int stall, input bit poke);
    int lat;
    bit done;
    logic [15:0] exp;
    exp = ref_prod(a, b, m);
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    rs1_reg   = a;
    rs2_reg   = b;
    mode      = m;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rs1_reg  = 8'($urandom);
    rs2_reg  = 8'($urandom);
    mode     = 2'($urandom);
    check("in_ready_busy", {31'd0, in_ready}, 32'd0);
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) done = 1'b1;
    end
    check("latency", 32'(lat), 32'(ref_lat(b, m)));
    check("product", {16'd0, mul_rd}, {16'd0, exp});
    for (int s = 0; s < stall; s++) begin
      if (poke) begin
        in_valid = 1'b1;
        rs1_reg  = 8'($urandom);
        rs2_reg  = 8'($urandom);
      end
      @(posedge clk); #1;
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_data", {16'd0, mul_rd}, {16'd0, exp});
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("handoff_valid", {31'd0, out_valid}, 32'd0);
    check("handoff_ready", {31'd0, in_ready}, 32'd1);
    check("idle_hold", {16'd0, mul_rd}, {16'd0, exp});
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rs1_reg   = '0;
    rs2_reg   = '0;
    mode      = 2'd0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mul_rd", {16'd0, mul_rd}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    run_op(8'd13, 8'd11, 2'd0, 0, 1'b0);
    run_op(8'hFD, 8'h05, 2'd1, 0, 1'b0);
    run_op(8'h80, 8'h80, 2'd1, 0, 1'b0);
    run_op(8'hFF, 8'hFF, 2'd2, 0, 1'b0);
    run_op(8'hFF, 8'hFF, 2'd0, 0, 1'b0);
    run_op(8'hFF, 8'hFF, 2'd3, 0, 1'b0);
    run_op(8'd13, 8'd11, 2'd0, 5, 1'b1);
    run_op(8'h55, 8'h01, 2'd0, 0, 1'b0);
    run_op(8'h55, 8'h00, 2'd0, 0, 1'b0);
    run_op(8'h55, 8'h80, 2'd0, 0, 1'b0);

    // Asynchronous reset in the middle of BUSY.
    rs1_reg  = 8'h7F;
    rs2_reg  = 8'h7F;
    mode     = 2'd0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_mul_rd", {16'd0, mul_rd}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(8'd2, 8'd3, 2'd0, 0, 1'b0);

    for (int t = 0; t < 60; t++) begin
      run_op(8'($urandom), 8'($urandom), 2'($urandom), int'($urandom_range(0, 3)),
             1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
